// File: rtl/i2s_stereo_bridge.sv
// i2s_stereo_bridge: I2S slave (codec masters bclk/LR) capturing stereo ADC frames and serializing FIFO-fed DAC frames.
// Latency: cap_valid 4 clk_100 cycles after the bclk rise carrying the right LSB; dac bit moves 4 cycles after a bclk fall.
// Backpressure: play_ready drops while the FIFO holds FIFO_DEPTH pairs; an empty pop replays the last pair or sends zeros.
//
// Ports:
//   clk_100, reset        system clock, asynchronous active-low reset
//   i2s_bclk/lrclk/adc    codec serial inputs (asynchronous, oversampled here)
//   i2s_dac_data          serial playback data to the codec
//   play_l/r/valid/ready  playback pair handshake into the FIFO; fifo_level = occupied entries
//   cap_l/r/valid         last captured stereo pair, cap_valid pulses on update
//   underrun              pulses when a left-slot pop finds the FIFO empty

module i2s_pair_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_vld_i,
    output logic                   wr_rdy_o,
    input  logic [WIDTH-1:0]       wr_dat_i,
    input  logic                   rd_pop_i,
    output logic [WIDTH-1:0]       rd_dat_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    // Small synchronous FIFO, head visible combinationally.
    // Latency: one cycle from push to head/level update.
    // Backpressure: wr_rdy_o low when full; pops on empty are ignored.
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push;
    logic             pop;

    assign wr_rdy_o = (level_q < DEPTH_L);
    assign empty_o  = (level_q == '0);
    assign push     = wr_vld_i & wr_rdy_o;
    assign pop      = rd_pop_i & ~empty_o;
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign level_o  = level_q;

    // DEPTH is a power of two, so the pointers wrap for free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

module i2s_stereo_bridge #(
    parameter int SAMPLE_WIDTH  = 24,
    parameter int SLOT_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int UNDERRUN_ZERO = 0
) (
    input  logic                          clk_100,
    input  logic                          reset,
    input  logic                          i2s_bclk,
    input  logic                          i2s_lrclk,
    input  logic                          i2s_adc_data,
    output logic                          i2s_dac_data,
    input  logic [SAMPLE_WIDTH-1:0]       play_l,
    input  logic [SAMPLE_WIDTH-1:0]       play_r,
    input  logic                          play_valid,
    output logic                          play_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [SAMPLE_WIDTH-1:0]       cap_l,
    output logic [SAMPLE_WIDTH-1:0]       cap_r,
    output logic                          cap_valid,
    output logic                          underrun
);
    localparam int CW = $clog2(SLOT_WIDTH + 1);
    localparam logic [CW-1:0] C_SW   = CW'(SAMPLE_WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(SAMPLE_WIDTH - 1);
    localparam logic [CW-1:0] C_SLOT = CW'(SLOT_WIDTH);

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] l;
        logic [SAMPLE_WIDTH-1:0] r;
    } pair_t;

    typedef enum logic {
        SLOT_L = 1'b0,
        SLOT_R = 1'b1
    } slot_e;

    // ---------------- input synchronizers and bclk edge events ----------------
    logic [2:0] bclk_sync_q;
    logic [1:0] lr_sync_q;
    logic [1:0] adc_sync_q;
    logic       rise_q;
    logic       fall_q;
    logic       lr_s;
    logic       adc_s;

    assign lr_s  = lr_sync_q[1];
    assign adc_s = adc_sync_q[1];

    // Edge events are registered so every framing/transmit decision sees the
    // synchronized LR/ADC values a full cycle after the edge was detected.
    always_ff @(posedge clk_100 or negedge reset) begin
        if (!reset) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            adc_sync_q  <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[1:0], i2s_bclk};
            lr_sync_q   <= {lr_sync_q[0], i2s_lrclk};
            adc_sync_q  <= {adc_sync_q[0], i2s_adc_data};
            rise_q      <= bclk_sync_q[1] & ~bclk_sync_q[2];
            fall_q      <= ~bclk_sync_q[1] & bclk_sync_q[2];
        end
    end

    // ---------------- playback FIFO ----------------
    pair_t play_pair;
    pair_t fifo_head;
    logic  fifo_empty;
    logic  fifo_pop;

    assign play_pair = {play_l, play_r};

    i2s_pair_fifo #(
        .WIDTH (2 * SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_100),
        .rst_ni   (reset),
        .wr_vld_i (play_valid),
        .wr_rdy_o (play_ready),
        .wr_dat_i (play_pair),
        .rd_pop_i (fifo_pop),
        .rd_dat_o (fifo_head),
        .empty_o  (fifo_empty),
        .level_o  (fifo_level)
    );

    // ---------------- framing, capture and transmit state ----------------
    logic [CW-1:0]           c_q, c_d;
    slot_e                   slot_q, slot_d;
    logic                    lr_prev_q, lr_prev_d;
    logic [SAMPLE_WIDTH-1:0] rx_q, rx_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                    left_seen_q, left_seen_d;
    pair_t                   cap_q, cap_d;
    logic                    cap_valid_q, cap_valid_d;
    logic                    underrun_q, underrun_d;
    pair_t                   tx_q, tx_d;
    pair_t                   last_q, last_d;
    logic                    dac_q, dac_d;
    logic [SAMPLE_WIDTH-1:0] tx_word;
    logic [SAMPLE_WIDTH-1:0] tx_shift;

    // Bit c of the slot is the MSB of the word shifted left by c.
    assign tx_word  = (slot_q == SLOT_R) ? tx_q.r : tx_q.l;
    assign tx_shift = tx_word << c_q;

    always_comb begin
        c_d         = c_q;
        slot_d      = slot_q;
        lr_prev_d   = lr_prev_q;
        rx_d        = rx_q;
        left_hold_d = left_hold_q;
        left_seen_d = left_seen_q;
        cap_d       = cap_q;
        cap_valid_d = 1'b0;
        underrun_d  = 1'b0;
        tx_d        = tx_q;
        last_d      = last_q;
        dac_d       = dac_q;
        fifo_pop    = 1'b0;

        if (rise_q) begin
            lr_prev_d = lr_s;
            if (lr_s != lr_prev_q) begin
                // New slot: restart the bit counter. The MSB follows one bclk later.
                c_d    = '0;
                slot_d = lr_s ? SLOT_R : SLOT_L;
                if (!lr_s) begin
                    // Start of a stereo frame: fetch the next playback pair.
                    // A same-cycle push into an empty FIFO is not bypassed.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        tx_d     = fifo_head;
                        last_d   = fifo_head;
                    end else begin
                        underrun_d = 1'b1;
                        if (UNDERRUN_ZERO != 0) begin
                            tx_d = '0;
                        end else begin
                            tx_d = last_q;
                        end
                    end
                end
            end else begin
                if (c_q < C_SW) begin
                    rx_d = {rx_q[SAMPLE_WIDTH-2:0], adc_s};
                end
                if (c_q < C_SLOT) begin
                    c_d = c_q + 1'b1;
                end
                // rx_d holds the complete sample once the LSB has been shifted in.
                if (c_q == C_LAST) begin
                    if (slot_q == SLOT_L) begin
                        left_hold_d = rx_d;
                        left_seen_d = 1'b1;
                    end else if (left_seen_q) begin
                        cap_d.l     = left_hold_q;
                        cap_d.r     = rx_d;
                        cap_valid_d = 1'b1;
                        left_seen_d = 1'b0;
                    end
                end
            end
        end

        // Idle (c saturated) and the padding bits of a slot drive zeros.
        if (fall_q) begin
            dac_d = (c_q < C_SW) ? tx_shift[SAMPLE_WIDTH-1] : 1'b0;
        end
    end

    always_ff @(posedge clk_100 or negedge reset) begin
        if (!reset) begin
            c_q         <= C_SLOT;
            slot_q      <= SLOT_L;
            lr_prev_q   <= 1'b0;
            rx_q        <= '0;
            left_hold_q <= '0;
            left_seen_q <= 1'b0;
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            tx_q        <= '0;
            last_q      <= '0;
            dac_q       <= 1'b0;
        end else begin
            c_q         <= c_d;
            slot_q      <= slot_d;
            lr_prev_q   <= lr_prev_d;
            rx_q        <= rx_d;
            left_hold_q <= left_hold_d;
            left_seen_q <= left_seen_d;
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
            underrun_q  <= underrun_d;
            tx_q        <= tx_d;
            last_q      <= last_d;
            dac_q       <= dac_d;
        end
    end

    assign i2s_dac_data = dac_q;
    assign cap_l        = cap_q.l;
    assign cap_r        = cap_q.r;
    assign cap_valid    = cap_valid_q;
    assign underrun     = underrun_q;
endmodule

// File: tb/tb_i2s_stereo_bridge.sv
`timescale 1ns/1ps
module tb_i2s_stereo_bridge;
    localparam int SW    = 24;
    localparam int SLOTW = 32;
    localparam int DEPTH = 4;
    localparam int HALF  = 16;   // bclk half period in clk_100 cycles
    localparam int NV    = 6;

    typedef struct packed {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
    } pair_t;

    typedef struct {
        logic [SW-1:0] adc_l;
        logic [SW-1:0] adc_r;
        bit            do_push;
        logic [SW-1:0] pl;
        logic [SW-1:0] pr;
        bit            exp_pop;   // frame starts with an LR change to left
        bit            exp_cap;   // frame must produce one capture of adc_l/adc_r
    } vec_t;

    logic clk_100 = 1'b0;
    logic reset = 1'b0;
    logic i2s_bclk = 1'b0;
    logic i2s_lrclk = 1'b0;
    logic i2s_adc_data = 1'b0;
    logic [SW-1:0] play_l = '0;
    logic [SW-1:0] play_r = '0;
    logic play_valid = 1'b0;

    logic dac0, dac1, rdy0, rdy1, cv0, cv1, ur0, ur1;
    logic [2:0] lvl0, lvl1;
    logic [SW-1:0] cl0, cr0, cl1, cr1;

    i2s_stereo_bridge #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOTW), .FIFO_DEPTH(DEPTH), .UNDERRUN_ZERO(0)) u0 (
        .clk_100(clk_100), .reset(reset), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
        .i2s_adc_data(i2s_adc_data), .i2s_dac_data(dac0), .play_l(play_l), .play_r(play_r),
        .play_valid(play_valid), .play_ready(rdy0), .fifo_level(lvl0), .cap_l(cl0), .cap_r(cr0),
        .cap_valid(cv0), .underrun(ur0));

    i2s_stereo_bridge #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOTW), .FIFO_DEPTH(DEPTH), .UNDERRUN_ZERO(1)) u1 (
        .clk_100(clk_100), .reset(reset), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
        .i2s_adc_data(i2s_adc_data), .i2s_dac_data(dac1), .play_l(play_l), .play_r(play_r),
        .play_valid(play_valid), .play_ready(rdy1), .fifo_level(lvl1), .cap_l(cl1), .cap_r(cr1),
        .cap_valid(cv1), .underrun(ur1));

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards and playback model
    pair_t cap_sb[$];
    pair_t dac_sb0[$];
    pair_t dac_sb1[$];
    pair_t mq[$];
    pair_t last_pair = '0;

    int ur_cnt0 = 0, ur_cnt1 = 0, cap_cnt = 0, last_cap_cyc = 0, lsb_rise_cyc = 0;

    always @(negedge clk_100) begin
        if (ur0) ur_cnt0++;
        if (ur1) ur_cnt1++;
        if (cv0 || cv1) begin
            pair_t e;
            cap_cnt++;
            last_cap_cyc = cyc;
            check("cap_valid_both", {62'd0, cv0, cv1}, 64'd3);
            if (cap_sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL cap_unexpected: got cap 0x%0h/0x%0h, want no cap_valid", cl0, cr0);
            end else begin
                e = cap_sb.pop_front();
                check("cap_pair_u0", {cl0, cr0}, e);
                check("cap_pair_u1", {cl1, cr1}, e);
            end
        end
    end

    // Codec model: drives bit positions k0..k1-1 of slot s and decodes the DAC line.
    logic [SW-1:0] dec0 [2];
    logic [SW-1:0] dec1 [2];
    int zero_bad0 = 0, zero_bad1 = 0;

    task automatic codec_bits(input bit s, input logic [SW-1:0] d, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            @(negedge clk_100);
            i2s_bclk = 1'b0;
            if (k == 0) i2s_lrclk = s;
            i2s_adc_data = (k >= 1 && k <= SW) ? d[SW-k] : 1'b0;
            repeat (HALF) @(negedge clk_100);
            if (k >= 1 && k <= SW) begin
                dec0[s][SW-k] = dac0;
                dec1[s][SW-k] = dac1;
            end else begin
                if (dac0 !== 1'b0) zero_bad0++;
                if (dac1 !== 1'b0) zero_bad1++;
            end
            i2s_bclk = 1'b1;
            if (s && k == SW) lsb_rise_cyc = cyc;
            repeat (HALF - 1) @(negedge clk_100);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        pair_t e0, e1;
        int u0s, u1s, cs;
        bit exp_ur;
        exp_ur = 1'b0;
        e0 = '0;
        e1 = '0;
        if (v.exp_pop) begin
            if (mq.size() > 0) begin
                e0 = mq.pop_front();
                e1 = e0;
                last_pair = e0;
            end else begin
                exp_ur = 1'b1;
                e0 = last_pair;
                e1 = '0;
            end
        end
        dac_sb0.push_back(e0);
        dac_sb1.push_back(e1);
        if (v.exp_cap) cap_sb.push_back({v.adc_l, v.adc_r});
        u0s = ur_cnt0;
        u1s = ur_cnt1;
        cs = cap_cnt;
        zero_bad0 = 0;
        zero_bad1 = 0;
        codec_bits(1'b0, v.adc_l, 0, SLOTW);
        codec_bits(1'b1, v.adc_r, 0, SLOTW);
        e0 = dac_sb0.pop_front();
        e1 = dac_sb1.pop_front();
        check($sformatf("dac_u0[%s]", tag), {dec0[0], dec0[1]}, e0);
        check($sformatf("dac_u1[%s]", tag), {dec1[0], dec1[1]}, e1);
        check($sformatf("dac_pad_zero[%s]", tag), 64'(zero_bad0 + zero_bad1), 64'd0);
        check($sformatf("underrun_u0[%s]", tag), 64'(ur_cnt0 - u0s), 64'(exp_ur));
        check($sformatf("underrun_u1[%s]", tag), 64'(ur_cnt1 - u1s), 64'(exp_ur));
        check($sformatf("cap_count[%s]", tag), 64'(cap_cnt - cs), 64'(v.exp_cap));
        check($sformatf("level[%s]", tag), {58'd0, lvl0, lvl1}, {58'd0, 3'(mq.size()), 3'(mq.size())});
        if (v.exp_cap) check($sformatf("cap_latency[%s]", tag), 64'(last_cap_cyc - lsb_rise_cyc), 64'd4);
    endtask

    task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        bit acc;
        acc = (mq.size() < DEPTH);
        @(negedge clk_100);
        play_l = l;
        play_r = r;
        play_valid = 1'b1;
        #1;
        check("play_ready", {62'd0, rdy0, rdy1}, {62'd0, acc, acc});
        @(negedge clk_100);
        play_valid = 1'b0;
        if (acc) mq.push_back({l, r});
        check("push_level", {58'd0, lvl0, lvl1}, {58'd0, 3'(mq.size()), 3'(mq.size())});
    endtask

    vec_t tbl [NV];
    vec_t hv;

    initial begin
        tbl[0] = '{adc_l:24'h123456, adc_r:24'hABCDEF, do_push:0, pl:24'h0,      pr:24'h0,      exp_pop:0, exp_cap:0};
        tbl[1] = '{adc_l:24'h123456, adc_r:24'hABCDEF, do_push:0, pl:24'h0,      pr:24'h0,      exp_pop:1, exp_cap:1};
        tbl[2] = '{adc_l:24'h000001, adc_r:24'hFFFFFF, do_push:1, pl:24'h7FFFFF, pr:24'h800001, exp_pop:1, exp_cap:1};
        tbl[3] = '{adc_l:24'h800000, adc_r:24'h7FFFFF, do_push:0, pl:24'h0,      pr:24'h0,      exp_pop:1, exp_cap:1};
        tbl[4] = '{adc_l:24'hA5A5A5, adc_r:24'h5A5A5A, do_push:1, pl:24'h000001, pr:24'hFFFFFE, exp_pop:1, exp_cap:1};
        tbl[5] = '{adc_l:24'h000000, adc_r:24'h000000, do_push:0, pl:24'h0,      pr:24'h0,      exp_pop:1, exp_cap:1};

        // Reset state
        repeat (5) @(negedge clk_100);
        check("rst_dac", {62'd0, dac0, dac1}, 64'd0);
        check("rst_cap_valid", {62'd0, cv0, cv1}, 64'd0);
        check("rst_underrun", {62'd0, ur0, ur1}, 64'd0);
        check("rst_level", {58'd0, lvl0, lvl1}, 64'd0);
        check("rst_cap_u0", {cl0, cr0}, 64'd0);
        check("rst_cap_u1", {cl1, cr1}, 64'd0);
        reset = 1'b1;
        @(negedge clk_100);
        check("rst_play_ready", {62'd0, rdy0, rdy1}, 64'd3);

        // Table-driven frames
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].do_push) push_pair(tbl[i].pl, tbl[i].pr);
            run_frame(tbl[i], $sformatf("vec%0d", i));
        end

        // Fill the FIFO: the fifth pair is refused until one frame pops
        for (int i = 0; i < 5; i++) push_pair(24'h111111 * (i + 1), 24'h0F0F00 + 24'(i));
        check("full_level", {58'd0, lvl0, lvl1}, {58'd0, 3'd4, 3'd4});
        hv = '{adc_l:24'h0C0FFE, adc_r:24'hFACADE, do_push:0, pl:24'h0, pr:24'h0, exp_pop:1, exp_cap:1};
        run_frame(hv, "fill_pop");
        push_pair(24'h555555, 24'h0F0F04);
        // Drain four pairs, then two underrun frames (replay vs zeros)
        for (int i = 0; i < 6; i++) begin
            hv.adc_l = 24'h100000 + 24'(i * 3 + 1);
            hv.adc_r = 24'h200000 + 24'(i * 5 + 2);
            run_frame(hv, $sformatf("drain%0d", i));
        end

        // Reset mid right slot, release mid left slot
        push_pair(24'h3C3C3C, 24'hC3C3C3);
        push_pair(24'h24680A, 24'h13579B);
        codec_bits(1'b0, 24'h111111, 0, SLOTW);
        codec_bits(1'b1, 24'h222222, 0, 12);
        reset = 1'b0;
        #1;
        check("midrst_dac", {62'd0, dac0, dac1}, 64'd0);
        check("midrst_cap_u0", {cl0, cr0}, 64'd0);
        check("midrst_cap_u1", {cl1, cr1}, 64'd0);
        check("midrst_level", {58'd0, lvl0, lvl1}, 64'd0);
        check("midrst_pulses", {60'd0, cv0, cv1, ur0, ur1}, 64'd0);
        mq.delete();
        last_pair = '0;
        codec_bits(1'b1, 24'h222222, 12, SLOTW);
        codec_bits(1'b0, 24'h333333, 0, 10);
        @(negedge clk_100);
        reset = 1'b1;
        begin
            int u0s, u1s, cs;
            u0s = ur_cnt0;
            u1s = ur_cnt1;
            cs = cap_cnt;
            zero_bad0 = 0;
            zero_bad1 = 0;
            codec_bits(1'b0, 24'h333333, 10, SLOTW);
            codec_bits(1'b1, 24'h444444, 0, SLOTW);
            check("postrst_no_cap", 64'(cap_cnt - cs), 64'd0);
            check("postrst_no_underrun", 64'(ur_cnt0 - u0s + ur_cnt1 - u1s), 64'd0);
            check("postrst_dac_right", {dec0[1], dec1[1]}, 64'd0);
            check("postrst_pad_zero", 64'(zero_bad0 + zero_bad1), 64'd0);
        end
        hv = '{adc_l:24'h123456, adc_r:24'hABCDEF, do_push:0, pl:24'h0, pr:24'h0, exp_pop:1, exp_cap:1};
        run_frame(hv, "postrst_frame2");

        repeat (4) @(negedge clk_100);
        check("cap_sb_empty", 64'(cap_sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2s_stereo_bridge.md
Name: i2s_stereo_bridge

Overview:
Parametrised I2S slave serializer/deserializer for the ADAU1761 audio path, running entirely in the clk_100 domain. The codec is bit-clock and frame master. The block oversamples the codec's bclk, LR and ADC data, captures stereo line-in frames and serializes headphone samples. Playback samples are buffered in a small FIFO with a valid/ready handshake, and underrun behaviour is selectable.

Parameters:
SAMPLE_WIDTH, 24, audio sample bits per channel (MSB-first, two's complement)
SLOT_WIDTH, 32, bclk periods per LR half-frame; must be >= SAMPLE_WIDTH+1
FIFO_DEPTH, 4, playback stereo entries; power of 2, >= 2
UNDERRUN_ZERO, 0, 0 = replay last sample on underrun, 1 = send zeros

Ports:
clk_100  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
i2s_bclk  in  1  codec bit clock, asynchronous
i2s_lrclk  in  1  codec frame clock; 0 = left slot, 1 = right slot
i2s_adc_data  in  1  serial capture data from codec
i2s_dac_data  out  1  serial playback data to codec
play_l  in  SAMPLE_WIDTH  left playback sample
play_r  in  SAMPLE_WIDTH  right playback sample
play_valid  in  1  playback pair offered
play_ready  out  1  FIFO can accept a pair
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
cap_l  out  SAMPLE_WIDTH  last captured left sample
cap_r  out  SAMPLE_WIDTH  last captured right sample
cap_valid  out  1  one-cycle pulse when cap_l/cap_r are updated
underrun  out  1  one-cycle pulse when a left-slot pop finds the FIFO empty

Behaviour:
- Reset (reset=0, asynchronous) clears all flops. Outputs: i2s_dac_data=0, cap_l=cap_r=0, cap_valid=0, underrun=0, fifo_level=0, play_ready=1 after release. The slot counter c is set to SLOT_WIDTH (idle), last-sample registers are cleared, and the left_seen flag is cleared.
- i2s_bclk, i2s_lrclk and i2s_adc_data each pass through a 2-flop synchronizer, plus a third bclk stage for edge detection.
  - rise event = synchronized bclk goes 0->1.
  - fall event = synchronized bclk goes 1->0.
- Slot framing, evaluated only on a rise event:
  - Compare the synchronized LR with LR_prev. If they differ (a change), set c=0 and latch the new slot.
  - Otherwise, if c_old < SAMPLE_WIDTH, shift the ADC bit into the rx shift register (MSB first), then increment c. c saturates at SLOT_WIDTH.
  - When c_old = SAMPLE_WIDTH-1 in the left slot: store rx to left_hold and set left_seen.
  - When c_old = SAMPLE_WIDTH-1 in the right slot and left_seen=1: cap_l<=left_hold, cap_r<=rx, cap_valid=1 for exactly one clk_100 cycle, then clear left_seen.
  - A right slot without a preceding complete left slot (first frame after reset) produces no cap_valid.
- Transmit, evaluated on a fall event:
  - If c < SAMPLE_WIDTH, i2s_dac_data <= tx_slot[SAMPLE_WIDTH-1-c].
  - Otherwise (including idle), i2s_dac_data <= 0.
  - tx_slot is tx_l in the left slot and tx_r in the right slot.
- FIFO pop happens in the cycle of a rise event with a change to LR=0.
  - Not empty: tx_l/tx_r <= head, head is removed, and last-sample registers are updated.
  - Empty: underrun pulses for 1 cycle. tx_l/tx_r <= last-sample registers (UNDERRUN_ZERO=0) or 0 (UNDERRUN_ZERO=1).
- FIFO push: play_ready = (fifo_level < FIFO_DEPTH). A push occurs when play_valid && play_ready.
  - Simultaneous push and pop: both happen and the level is unchanged.
  - Push and pop in the same cycle on an empty FIFO: the pop reports underrun, with no bypass. The pushed entry is stored.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is exact and registered.
- Latency: cap_valid asserts 4 clk_100 cycles after the raw bclk rising edge that samples the right-channel LSB (2 sync + edge detect + output register).
- Reset asserted mid-frame aborts everything. After release the block stays idle until the first LR change, and the partial first frame is discarded.
- bclk limit: bclk must be <= clk_100/8.

Test Plan:
- Reset then idle bclk/LR toggling with the FIFO empty -> i2s_dac_data stays 0, underrun pulses once per frame, and cap_valid never asserts during the first (partial) frame.
- Codec model drives left=24'h123456, right=24'hABCDEF (SLOT_WIDTH=32, bclk=3.072 MHz) -> cap_l=24'h123456, cap_r=24'hABCDEF, with one cap_valid pulse per frame.
- Push the pair (24'h7FFFFF, 24'h800001) -> the serial output shows MSB one bclk after the LR edge, 24 bits per slot, then zeros for 8 bits; the codec model decodes the same values.
- Push 5 pairs with FIFO_DEPTH=4 -> play_ready deasserts after 4 and fifo_level=4. After one frame the level is 3 and the 5th pair is accepted.
- Drain the FIFO with UNDERRUN_ZERO=0 -> the last pair repeats and underrun pulses. Rerun with UNDERRUN_ZERO=1 -> all-zero slots.
- Assert reset mid right slot -> outputs clear immediately. After release, the first full frame has no cap_valid and the second frame captures correctly.
